// File: rtl/fifo_singleclock_fwft_pkt.sv
// Single-clock first-word-fall-through FIFO with optional packet commit/discard.
// Every output is a register loaded from the next-state view of the pointers.
module fifo_singleclock_fwft_pkt #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 32,
    parameter int PROG_FULL   = 0,
    parameter int PROG_EMPTY  = 0,
    parameter int PACKET_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             din,
    input  logic                         wr_commit,
    input  logic                         wr_discard,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         prog_full,
    output logic                         empty,
    output logic                         prog_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         wr_err,
    output logic                         rd_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P      = PW'(DEPTH);
    localparam logic [PW-1:0] PROG_FULL_P  = PW'(PROG_FULL);
    localparam logic [PW-1:0] PROG_EMPTY_P = PW'(PROG_EMPTY);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    cm_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [WIDTH-1:0] dout_r;
    logic             full_r;
    logic             prog_full_r;
    logic             empty_r;
    logic             prog_empty_r;
    logic [PW-1:0]    count_r;
    logic             wr_err_r;
    logic             rd_err_r;

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [PW-1:0]    wr_adv_s;
    logic [PW-1:0]    wr_nxt_s;
    logic [PW-1:0]    cm_nxt_s;
    logic [PW-1:0]    rd_nxt_s;
    logic [PW-1:0]    cnt_nxt_s;
    logic [PW-1:0]    tot_nxt_s;
    logic [WIDTH-1:0] head_s;

    // Next-state pointers, occupancy and the word that will sit on dout.
    always_comb begin
        wr_acc_s = wr_en & ~full_r;
        rd_acc_s = rd_en & ~empty_r;
        wr_adv_s = wr_ptr_r + {{AW{1'b0}}, wr_acc_s};
        rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, rd_acc_s};
        wr_nxt_s = wr_adv_s;
        cm_nxt_s = wr_adv_s;
        if (PACKET_MODE != 0) begin
            // Commit wins over discard; discard rewinds to the committed mark.
            if (wr_commit) begin
                wr_nxt_s = wr_adv_s;
                cm_nxt_s = wr_adv_s;
            end else if (wr_discard) begin
                wr_nxt_s = cm_ptr_r;
                cm_nxt_s = cm_ptr_r;
            end else begin
                wr_nxt_s = wr_adv_s;
                cm_nxt_s = cm_ptr_r;
            end
        end else begin
            wr_nxt_s = wr_adv_s;
            cm_nxt_s = wr_adv_s;
        end
        cnt_nxt_s = cm_nxt_s - rd_nxt_s;
        tot_nxt_s = wr_nxt_s - rd_nxt_s;
        // The slot being written this edge is not in memory yet: bypass din.
        if (wr_acc_s && (rd_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
            head_s = din;
        end else begin
            head_s = mem_r[rd_nxt_s[AW-1:0]];
        end
    end

    // Storage array; no reset needed since occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            cm_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            dout_r       <= {WIDTH{1'b0}};
            full_r       <= 1'b0;
            prog_full_r  <= 1'b0;
            empty_r      <= 1'b1;
            prog_empty_r <= 1'b1;
            count_r      <= {PW{1'b0}};
            wr_err_r     <= 1'b0;
            rd_err_r     <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_nxt_s;
            cm_ptr_r     <= cm_nxt_s;
            rd_ptr_r     <= rd_nxt_s;
            if (cnt_nxt_s != {PW{1'b0}}) begin
                dout_r <= head_s;
            end else begin
                dout_r <= dout_r;
            end
            full_r       <= (tot_nxt_s == DEPTH_P);
            prog_full_r  <= (PROG_FULL == 0) ? (tot_nxt_s == DEPTH_P)
                                             : (tot_nxt_s >= PROG_FULL_P);
            empty_r      <= (cnt_nxt_s == {PW{1'b0}});
            prog_empty_r <= (PROG_EMPTY == 0) ? (cnt_nxt_s == {PW{1'b0}})
                                              : (cnt_nxt_s <= PROG_EMPTY_P);
            count_r      <= cnt_nxt_s;
            wr_err_r     <= wr_en & full_r;
            rd_err_r     <= rd_en & empty_r;
        end
    end

    assign dout       = dout_r;
    assign full       = full_r;
    assign prog_full  = prog_full_r;
    assign empty      = empty_r;
    assign prog_empty = prog_empty_r;
    assign count      = count_r;
    assign wr_err     = wr_err_r;
    assign rd_err     = rd_err_r;

endmodule

// File: tb/tb_fifo_singleclock_fwft_pkt.sv
// Directed bench: one non-packet FIFO with thresholds and one packet-mode FIFO, both DEPTH=4.
module tb_fifo_singleclock_fwft_pkt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       np_rst, np_wr_en, np_commit, np_discard, np_rd_en;
    logic [7:0] np_din, np_dout;
    logic       np_full, np_prog_full, np_empty, np_prog_empty, np_wr_err, np_rd_err;
    logic [2:0] np_count;

    logic       pk_rst, pk_wr_en, pk_commit, pk_discard, pk_rd_en;
    logic [7:0] pk_din, pk_dout;
    logic       pk_full, pk_prog_full, pk_empty, pk_prog_empty, pk_wr_err, pk_rd_err;
    logic [2:0] pk_count;

    fifo_singleclock_fwft_pkt #(.WIDTH(8), .DEPTH(4), .PROG_FULL(3), .PROG_EMPTY(1),
                                .PACKET_MODE(0)) dut_np (
        .clk(clk), .rst(np_rst), .wr_en(np_wr_en), .din(np_din),
        .wr_commit(np_commit), .wr_discard(np_discard), .rd_en(np_rd_en),
        .dout(np_dout), .full(np_full), .prog_full(np_prog_full), .empty(np_empty),
        .prog_empty(np_prog_empty), .count(np_count), .wr_err(np_wr_err), .rd_err(np_rd_err)
    );

    fifo_singleclock_fwft_pkt #(.WIDTH(8), .DEPTH(4), .PROG_FULL(0), .PROG_EMPTY(0),
                                .PACKET_MODE(1)) dut_pk (
        .clk(clk), .rst(pk_rst), .wr_en(pk_wr_en), .din(pk_din),
        .wr_commit(pk_commit), .wr_discard(pk_discard), .rd_en(pk_rd_en),
        .dout(pk_dout), .full(pk_full), .prog_full(pk_prog_full), .empty(pk_empty),
        .prog_empty(pk_prog_empty), .count(pk_count), .wr_err(pk_wr_err), .rd_err(pk_rd_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dout is only meaningful while a readable word exists.
    task automatic np_exp(input string tag, input logic [7:0] d, input logic [2:0] c,
                          input logic e, input logic f, input logic we, input logic re);
        if (!e) check({tag, ".dout"}, 32'(np_dout), 32'(d));
        check({tag, ".count"},  32'(np_count),  32'(c));
        check({tag, ".empty"},  32'(np_empty),  32'(e));
        check({tag, ".full"},   32'(np_full),   32'(f));
        check({tag, ".wr_err"}, 32'(np_wr_err), 32'(we));
        check({tag, ".rd_err"}, 32'(np_rd_err), 32'(re));
    endtask

    task automatic pk_exp(input string tag, input logic [7:0] d, input logic [2:0] c,
                          input logic e, input logic f, input logic we, input logic re);
        if (!e) check({tag, ".dout"}, 32'(pk_dout), 32'(d));
        check({tag, ".count"},  32'(pk_count),  32'(c));
        check({tag, ".empty"},  32'(pk_empty),  32'(e));
        check({tag, ".full"},   32'(pk_full),   32'(f));
        check({tag, ".wr_err"}, 32'(pk_wr_err), 32'(we));
        check({tag, ".rd_err"}, 32'(pk_rd_err), 32'(re));
    endtask

    initial begin
        np_rst = 1'b1; np_wr_en = 1'b0; np_commit = 1'b0; np_discard = 1'b0;
        np_rd_en = 1'b0; np_din = 8'h00;
        pk_rst = 1'b1; pk_wr_en = 1'b0; pk_commit = 1'b0; pk_discard = 1'b0;
        pk_rd_en = 1'b0; pk_din = 8'h00;
        tick();
        np_wr_en = 1'b1; np_din = 8'hEE; pk_rd_en = 1'b1;
        tick();
        np_exp("np_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("np_rst.dout", 32'(np_dout), 32'h0);
        check("np_rst.prog_empty", 32'(np_prog_empty), 32'd1);
        check("np_rst.prog_full", 32'(np_prog_full), 32'd0);
        pk_exp("pk_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pk_rst.dout", 32'(pk_dout), 32'h0);
        check("pk_rst.prog_empty", 32'(pk_prog_empty), 32'd1);
        check("pk_rst.prog_full", 32'(pk_prog_full), 32'd0);
        pk_rd_en = 1'b0;

        // Non-packet fill, overflow, drain, underflow
        np_rst = 1'b0; np_din = 8'h11;
        tick();
        np_exp("np_w1", 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("np_w1.prog_empty", 32'(np_prog_empty), 32'd1);
        np_din = 8'h22;
        tick();
        np_exp("np_w2", 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("np_w2.prog_empty", 32'(np_prog_empty), 32'd0);
        check("np_w2.prog_full", 32'(np_prog_full), 32'd0);
        np_din = 8'h33;
        tick();
        np_exp("np_w3", 8'h11, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("np_w3.prog_full", 32'(np_prog_full), 32'd1);
        np_din = 8'h44;
        tick();
        np_exp("np_w4", 8'h11, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        np_din = 8'h55;
        tick();
        np_exp("np_w5", 8'h11, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        np_wr_en = 1'b0; np_rd_en = 1'b1;
        tick();
        np_exp("np_r1", 8'h22, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_r2", 8'h33, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_r3", 8'h44, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_r4", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_r5", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Single-word latency
        np_rd_en = 1'b0; np_wr_en = 1'b1; np_din = 8'hA5;
        tick();
        np_exp("np_a5", 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        np_wr_en = 1'b0; np_rd_en = 1'b1;
        tick();
        np_exp("np_a5rd", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        np_rd_en = 1'b0;

        // Full with simultaneous read and write, then wrap-around order
        np_wr_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            np_din = 8'(i);
            tick();
        end
        np_wr_en = 1'b0;
        tick();
        np_exp("np_fill", 8'h01, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        np_wr_en = 1'b1; np_rd_en = 1'b1; np_din = 8'h99;
        tick();
        np_exp("np_rw_full", 8'h02, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        np_rd_en = 1'b0;
        tick();
        np_exp("np_w99", 8'h02, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        np_wr_en = 1'b0; np_rd_en = 1'b1;
        tick();
        np_exp("np_wr1", 8'h03, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_wr2", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_wr3", 8'h99, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        np_exp("np_wr4", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream, then first write right after release
        np_rd_en = 1'b0; np_wr_en = 1'b1; np_din = 8'hC1;
        tick();
        np_din = 8'hC2;
        tick();
        np_exp("np_pre", 8'hC1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        np_rst = 1'b1;
        tick();
        np_exp("np_mrst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("np_mrst.dout", 32'(np_dout), 32'h0);
        check("np_mrst.prog_empty", 32'(np_prog_empty), 32'd1);
        check("np_mrst.prog_full", 32'(np_prog_full), 32'd0);
        np_rst = 1'b0; np_din = 8'hAB;
        tick();
        np_exp("np_post", 8'hAB, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        np_din = 8'hBC; np_discard = 1'b1;
        tick();
        np_exp("np_nodisc", 8'hAB, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        np_wr_en = 1'b0; np_discard = 1'b0;

        // Packet mode: uncommitted words are invisible
        pk_rst = 1'b0; pk_wr_en = 1'b1; pk_din = 8'hA0;
        tick();
        pk_exp("pk_u1", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pk_din = 8'hA1;
        tick();
        pk_din = 8'hA2;
        tick();
        pk_exp("pk_u3", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pk_wr_en = 1'b0; pk_commit = 1'b1;
        tick();
        pk_exp("pk_cm", 8'hA0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        pk_commit = 1'b0; pk_wr_en = 1'b1; pk_din = 8'hA3;
        tick();
        pk_exp("pk_u4", 8'hA0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pk_u4.prog_full", 32'(pk_prog_full), 32'd1);
        pk_din = 8'hEE; pk_discard = 1'b1;
        tick();
        pk_exp("pk_disc", 8'hA0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        pk_discard = 1'b0; pk_din = 8'hA3; pk_commit = 1'b1;
        tick();
        pk_exp("pk_wcm", 8'hA0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        pk_commit = 1'b0; pk_wr_en = 1'b0; pk_rd_en = 1'b1;
        tick();
        pk_exp("pk_rd", 8'hA1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        pk_rd_en = 1'b0; pk_discard = 1'b1;
        tick();
        pk_exp("pk_disc_nop", 8'hA1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        pk_wr_en = 1'b1; pk_din = 8'h77; pk_commit = 1'b1;
        tick();
        pk_exp("pk_cm_disc", 8'hA1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        pk_wr_en = 1'b0; pk_commit = 1'b0; pk_discard = 1'b0; pk_rd_en = 1'b1;
        tick();
        pk_exp("pk_d1", 8'hA2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pk_exp("pk_d2", 8'hA3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pk_exp("pk_d3", 8'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pk_exp("pk_d4", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Write+commit into empty FIFO, then discard of a trailing partial packet
        pk_rd_en = 1'b0; pk_wr_en = 1'b1; pk_din = 8'h5A; pk_commit = 1'b1;
        tick();
        pk_exp("pk_5a", 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pk_commit = 1'b0; pk_din = 8'h66;
        tick();
        pk_exp("pk_66", 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pk_wr_en = 1'b0; pk_discard = 1'b1;
        tick();
        pk_exp("pk_66d", 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pk_discard = 1'b0; pk_rd_en = 1'b1;
        tick();
        pk_exp("pk_5ard", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pk_rd_en = 1'b0; pk_commit = 1'b1;
        tick();
        pk_exp("pk_cm_nop", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pk_commit = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_singleclock_fwft_pkt.md
FIFO_SINGLECLOCK_FWFT_PKT -- requirements
Module: fifo_singleclock_fwft_pkt

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 32: total word capacity, a power of two and at least 2.
REQ-003 Parameter PROG_FULL, default 0: prog_full threshold in words; 0 makes prog_full equal full.
REQ-004 Parameter PROG_EMPTY, default 0: prog_empty threshold in words; 0 makes prog_empty equal empty.
REQ-005 Parameter PACKET_MODE, default 0: 1 enables commit/discard semantics; 0 makes every accepted write immediately readable.
REQ-006 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wr_en  in  1  write request.
REQ-009 din  in  WIDTH  write data.
REQ-010 wr_commit  in  1  packet mode: makes all uncommitted words readable.
REQ-011 wr_discard  in  1  packet mode: drops all uncommitted words.
REQ-012 rd_en  in  1  consumes the word on dout.
REQ-013 dout  out  WIDTH  head word, first-word fall-through, registered.
REQ-014 full  out  1  total stored words (committed plus uncommitted) equals DEPTH.
REQ-015 prog_full  out  1  total stored words >= PROG_FULL, or equal to full when PROG_FULL=0.
REQ-016 empty  out  1  no readable word on dout.
REQ-017 prog_empty  out  1  count <= PROG_EMPTY, or equal to empty when PROG_EMPTY=0.
REQ-018 count  out  $clog2(DEPTH+1)  readable (committed) words, including the one on dout.
REQ-019 wr_err  out  1  one-cycle pulse: write refused.
REQ-020 rd_err  out  1  one-cycle pulse: read of empty FIFO.

Function
REQ-021 All outputs SHALL be driven from registered state only; there is no combinational path from any input to any output.
REQ-022 A write SHALL be accepted when wr_en=1 and full=0 in the same cycle.
REQ-023 wr_en=1 while full=1 SHALL drop din, leave all state unchanged and pulse wr_err in the next cycle.
REQ-024 A read SHALL occur when rd_en=1 and empty=0; dout then advances to the next readable word, or empty asserts, after that edge.
REQ-025 rd_en=1 while empty=1 SHALL be ignored and pulse rd_err in the next cycle.
REQ-026 Write-to-read latency, non-packet mode: a word written at edge k into an empty FIFO SHALL appear on dout, with empty=0 and count=1, in the cycle after edge k.
REQ-027 Packet mode, commit: words become readable only by wr_commit; after commit edge k, count and empty SHALL reflect them in the cycle after k, with the same 1-cycle latency as REQ-026.
REQ-028 wr_commit asserted with an accepted write in the same cycle SHALL include that word in the commit.
REQ-029 wr_discard SHALL rewind the write pointer to the last committed position; an accepted write in the same cycle SHALL also be discarded.
REQ-030 wr_commit and wr_discard asserted together SHALL act as wr_commit; wr_discard is ignored.
REQ-031 Commit or discard with no uncommitted words SHALL be a no-op.
REQ-032 Discard SHALL never affect committed words or dout.
REQ-033 In non-packet mode, wr_commit and wr_discard SHALL be ignored.
REQ-034 full and prog_full SHALL count uncommitted words; count, empty and prog_empty SHALL count committed words only.
REQ-035 Simultaneous accepted read and write SHALL keep the total word count unchanged.
REQ-036 Read and write into a full FIFO in the same cycle SHALL perform only the read, since full gates the write that cycle.
REQ-037 Pointers SHALL wrap modulo DEPTH, with an extra MSB distinguishing full from empty; data order SHALL be strictly preserved across wrap-around.

Reset
REQ-038 While rst=1: pointers and count SHALL be 0, empty=1, prog_empty=1, full=0, prog_full=0 (1 if PROG_FULL=0 is not met), wr_err=0, rd_err=0, dout=0.
REQ-039 Reset mid-operation SHALL drop all committed and uncommitted words; inputs during rst=1 are ignored.
REQ-040 The first write SHALL be accepted in the first cycle with rst=0.

Verification
REQ-041 Non-packet, WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 -> full=1; a 5th write of 0x55 pulses wr_err; reading 4 words returns 0x11..0x44; then empty=1.
REQ-042 Single write 0xA5 at edge k -> dout=0xA5, empty=0, count=1 in cycle k+1; rd_en -> empty=1 and count=0 in the following cycle.
REQ-043 PACKET_MODE=1: write 3 words, no commit -> empty=1, count=0; commit -> count=3; write 2 more and discard -> count stays 3 and full=0.
REQ-044 Full FIFO with rd_en=1 and wr_en=1 in the same cycle -> read occurs, write is refused, wr_err pulses, count=DEPTH-1.
REQ-045 PROG_FULL=3, PROG_EMPTY=1, DEPTH=4: prog_full asserts at 3 words; prog_empty deasserts at 2 readable words; assert rst mid-stream -> all REQ-038 values in the next cycle.
